spi_sram_target: RTL

- SPI mode-0 responder that emulates the serial SRAM the CPU's memory controller drives on si/so/sclk/sram_ce.
- Implements the READ, WRITE, RDMR and WRMR commands, with a 24-bit address and an internal byte array.
- Used as an on-chip SRAM stand-in and as the far-end model in system benches; synthesizable.
- Oversamples the SPI pins with the system clock; no logic is clocked by sclk.

---
 rtl/spi_sram_pkg.sv | 41 ++++
 rtl/spi_sram_target_sync.sv | 44 ++++
 rtl/spi_sram_target.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_sram_pkg.sv
// Shared constants, state encoding and helpers for the SPI serial-SRAM target.
package spi_sram_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned ADDR_BITS = 24;
  localparam int unsigned PAGE_W    = 5;
  localparam int unsigned CNT_W     = 5;

  localparam logic [7:0] OPC_READ  = 8'h03;
  localparam logic [7:0] OPC_WRITE = 8'h02;
  localparam logic [7:0] OPC_RDMR  = 8'h05;
  localparam logic [7:0] OPC_WRMR  = 8'h01;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_SEQ  = 2'b01;
  localparam logic [1:0] MODE_PAGE = 2'b10;

  localparam logic [7:0] MODE_RESET = 8'h40;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ,
    WRITE,
    RDMR,
    WRMR,
    IGNORE
  } state_t;

  // Opcodes this target understands.
  function automatic logic opcode_known(input logic [7:0] op);
    return (op == OPC_READ) || (op == OPC_WRITE) || (op == OPC_RDMR) || (op == OPC_WRMR);
  endfunction

  // Modes 00 and 11 both mean single-byte access.
  function automatic logic is_byte_mode(input logic [1:0] m);
    return (m == MODE_BYTE) || (m == 2'b11);
  endfunction

endpackage

// File: rtl/spi_sram_target_sync.sv
// Two-flop synchronizers on the SPI pins plus sclk edge detection in the clk domain.
module spi_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic sram_ce,
  input  logic si,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ce_n_s,
  output logic si_s
);

  logic r_sclk_m, r_sclk_s, r_sclk_q;
  logic r_ce_m, r_ce_s;
  logic r_si_m, r_si_s;

  // Synchronizer chains; chip enable idles deasserted (high).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_m <= 1'b0;
      r_sclk_s <= 1'b0;
      r_sclk_q <= 1'b0;
      r_ce_m   <= 1'b1;
      r_ce_s   <= 1'b1;
      r_si_m   <= 1'b0;
      r_si_s   <= 1'b0;
    end else begin
      r_sclk_m <= sclk;
      r_sclk_s <= r_sclk_m;
      r_sclk_q <= r_sclk_s;
      r_ce_m   <= sram_ce;
      r_ce_s   <= r_ce_m;
      r_si_m   <= si;
      r_si_s   <= r_si_m;
    end
  end

  assign sclk_rise = r_sclk_s & ~r_sclk_q;
  assign sclk_fall = ~r_sclk_s & r_sclk_q;
  assign ce_n_s    = r_ce_s;
  assign si_s      = r_si_s;

endmodule

// File: rtl/spi_sram_target.sv
// SPI mode-0 serial SRAM responder (READ/WRITE/RDMR/WRMR), oversampled by clk.
module spi_sram_target
  import spi_sram_pkg::*;
#(
  parameter int unsigned DEPTH = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic sram_ce,
  input  logic si,
  output logic so,
  output logic so_oe,
  output logic cmd_error
);

  localparam int unsigned ADDR_W    = $clog2(DEPTH);
  localparam int unsigned PAGE_MASK = (1 << PAGE_W) - 1;

  logic w_rise, w_fall, w_ce_n, w_si;

  state_t r_state, w_state_nxt;
  logic [2:0]        r_bit_cnt;
  logic [CNT_W-1:0]  r_addr_cnt;
  logic [BYTE_W-1:0] r_shreg;
  logic [BYTE_W-1:0] r_mode;
  logic [ADDR_W-1:0] r_addr;
  logic              r_is_read;
  logic              r_fetch;
  logic              r_wr_pend;
  logic [BYTE_W-1:0] r_wr_data;
  logic              r_so, r_so_oe, r_cmd_error;
  logic [BYTE_W-1:0] r_mem [DEPTH];

  logic [BYTE_W-1:0] w_shift_in;
  logic              w_last_bit;
  logic [PAGE_W-1:0] w_page_lo;
  logic [ADDR_W-1:0] w_addr_next;
  logic              w_tx, w_tx_nxt;
  logic              w_so_nxt, w_so_oe_nxt, w_cmd_error_nxt;

  spi_edge_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .sram_ce   (sram_ce),
    .si        (si),
    .sclk_rise (w_rise),
    .sclk_fall (w_fall),
    .ce_n_s    (w_ce_n),
    .si_s      (w_si)
  );

  assign w_shift_in = {r_shreg[BYTE_W-2:0], w_si};
  assign w_last_bit = w_rise & (r_bit_cnt == 3'd7);
  assign w_page_lo  = r_addr[PAGE_W-1:0] + PAGE_W'(1);
  assign w_tx       = (r_state == READ) || (r_state == RDMR);
  assign w_tx_nxt   = (w_state_nxt == READ) || (w_state_nxt == RDMR);

  // Address advance according to the mode register burst field.
  always_comb begin
    w_addr_next = r_addr;
    case (r_mode[7:6])
      MODE_SEQ:  w_addr_next = r_addr + ADDR_W'(1);
      MODE_PAGE: w_addr_next = (r_addr & ~ADDR_W'(PAGE_MASK)) | ADDR_W'(w_page_lo);
      default:   w_addr_next = r_addr;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; a deasserted chip enable overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (w_ce_n) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = CMD;
        CMD: if (w_last_bit) begin
          case (w_shift_in)
            OPC_READ, OPC_WRITE: w_state_nxt = ADDR;
            OPC_RDMR:            w_state_nxt = RDMR;
            OPC_WRMR:            w_state_nxt = WRMR;
            default:             w_state_nxt = IGNORE;
          endcase
        end
        ADDR: begin
          if (r_fetch) w_state_nxt = READ;
          else if (w_rise && (r_addr_cnt == CNT_W'(ADDR_BITS - 1)) && !r_is_read)
            w_state_nxt = WRITE;
        end
        READ, WRITE: if (w_last_bit && is_byte_mode(r_mode[7:6])) w_state_nxt = IGNORE;
        WRMR: if (w_last_bit) w_state_nxt = IGNORE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Output next values: so updates on sclk falls while transmitting.
  always_comb begin
    w_so_nxt        = r_so;
    w_so_oe_nxt     = 1'b0;
    w_cmd_error_nxt = 1'b0;
    if (w_ce_n) begin
      w_so_nxt = 1'b0;
    end else begin
      if (w_tx && w_fall) w_so_nxt = r_shreg[BYTE_W-1];
      if (w_tx_nxt) w_so_oe_nxt = r_so_oe | (w_tx & w_fall);
      if ((r_state == CMD) && w_last_bit && !opcode_known(w_shift_in)) w_cmd_error_nxt = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_so        <= 1'b0;
      r_so_oe     <= 1'b0;
      r_cmd_error <= 1'b0;
    end else begin
      r_so        <= w_so_nxt;
      r_so_oe     <= w_so_oe_nxt;
      r_cmd_error <= w_cmd_error_nxt;
    end
  end

  // Datapath: shift register, counters, address, mode register, write staging.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt  <= 3'd0;
      r_addr_cnt <= '0;
      r_shreg    <= '0;
      r_mode     <= MODE_RESET;
      r_addr     <= '0;
      r_is_read  <= 1'b0;
      r_fetch    <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_wr_data  <= '0;
    end else begin
      r_wr_pend <= 1'b0;
      if (r_wr_pend) r_addr <= w_addr_next;
      if (w_ce_n) begin
        r_bit_cnt  <= 3'd0;
        r_addr_cnt <= '0;
        r_fetch    <= 1'b0;
      end else begin
        r_fetch <= 1'b0;
        if (r_fetch) r_shreg <= r_mem[r_addr];
        if (w_rise) begin
          case (r_state)
            CMD: begin
              r_shreg    <= w_shift_in;
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              r_addr_cnt <= '0;
              if (r_bit_cnt == 3'd7) begin
                r_is_read <= (w_shift_in == OPC_READ);
                if (w_shift_in == OPC_RDMR) r_shreg <= r_mode;
              end
            end
            ADDR: if (!r_fetch) begin
              r_addr     <= {r_addr[ADDR_W-2:0], w_si};
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              r_addr_cnt <= r_addr_cnt + CNT_W'(1);
              if ((r_addr_cnt == CNT_W'(ADDR_BITS - 1)) && r_is_read) r_fetch <= 1'b1;
            end
            READ: begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_addr  <= w_addr_next;
                r_shreg <= r_mem[w_addr_next];
              end
            end
            WRITE: begin
              r_shreg   <= w_shift_in;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_wr_pend <= 1'b1;
                r_wr_data <= w_shift_in;
              end
            end
            RDMR: begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_shreg <= r_mode;
            end
            WRMR: begin
              r_shreg   <= w_shift_in;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_mode <= w_shift_in;
            end
            default: ;
          endcase
        end
        if (w_fall && w_tx) r_shreg <= {r_shreg[BYTE_W-2:0], 1'b0};
      end
    end
  end

  // Backing array; a completed write byte lands one cycle after its last bit.
  always_ff @(posedge clk) begin
    if (r_wr_pend) r_mem[r_addr] <= r_wr_data;
  end

  assign so        = r_so;
  assign so_oe     = r_so_oe;
  assign cmd_error = r_cmd_error;

endmodule
